// File: rtl/mtimer_pkg.sv
// Shared constants and types for the machine timer: register offsets,
// bus access size encoding, CTRL field layout and a decode helper.
package mtimer_pkg;

  // Register offsets within the 256-byte window.
  localparam logic [7:0] OFF_MTIME_LO    = 8'h00;
  localparam logic [7:0] OFF_MTIME_HI    = 8'h04;
  localparam logic [7:0] OFF_MTIMECMP_LO = 8'h08;
  localparam logic [7:0] OFF_MTIMECMP_HI = 8'h0C;
  localparam logic [7:0] OFF_CTRL        = 8'h10;
  localparam logic [7:0] OFF_STATUS      = 8'h14;

  // Only word accesses are decoded.
  localparam logic [2:0] MEM_WORD = 3'b010;

  // CTRL bit positions.
  localparam int CTRL_CNT_EN_BIT = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int CTRL_PRESC_LSB  = 8;

  // Storage width reserved for the prescale field; the module parameter
  // PRESC_W selects how many low bits are actually implemented.
  localparam int PRESC_W_MAX = 16;

  typedef struct packed {
    logic [PRESC_W_MAX-1:0] prescale;
    logic                   irq_en;
    logic                   cnt_en;
  } ctrl_t;

  // True for a naturally aligned word access.
  function automatic logic word_access(input logic [2:0] mem_type,
                                       input logic [1:0] addr_lsb);
    return (mem_type == MEM_WORD) && (addr_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/mtimer_if.sv
// Data-memory bus as seen by the timer: the core drives strobes, address,
// size and write data; the timer returns combinational read data.
interface mtimer_if;

  logic        rd_en;
  logic        wr_en;
  logic [2:0]  mem_type;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output rd_en, wr_en, mem_type, addr, wdata,
    input  rdata
  );

  modport slave (
    input  rd_en, wr_en, mem_type, addr, wdata,
    output rdata
  );

endinterface

// File: rtl/mtimer_prescaler.sv
// Prescale counter for mtime: counts 0..prescale while enabled and emits a
// one-cycle tick when the count reaches prescale. clr restarts the count.
module mtimer_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cnt_en,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               clr,
  output logic               tick
);

  logic [PRESC_W-1:0] presc_cnt_reg;

  assign tick = cnt_en && (presc_cnt_reg == prescale);

  // Count register; clear has priority, a tick wraps to zero, otherwise hold
  // or advance depending on cnt_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt_reg <= '0;
    end else if (clr) begin
      presc_cnt_reg <= '0;
    end else if (tick) begin
      presc_cnt_reg <= '0;
    end else if (cnt_en) begin
      presc_cnt_reg <= presc_cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/mtimer.sv
// Memory-mapped machine timer: 64-bit mtime with prescaler, 64-bit
// mtimecmp, CTRL/STATUS registers, tear-free high-half read via a shadow,
// and a registered level interrupt while mtime >= mtimecmp.
module mtimer
  import mtimer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          PRESC_W   = 8
) (
  input  logic     clk,
  input  logic     rst,
  mtimer_if.slave  bus,
  output logic     tm_interupt
);

  logic [63:0] mtime_reg;
  logic [63:0] mtimecmp;
  logic [31:0] hi_shadow_reg;
  ctrl_t       ctrl_reg;
  logic        tm_interupt_reg;

  logic        hit;
  logic [7:0]  off;
  logic        rd_hit;
  logic        wr_hit;
  logic        wr_mtime_lo;
  logic        wr_mtime_hi;
  logic        wr_ctrl;
  logic        rd_mtime_lo;
  logic        tick;
  logic        cmp_ge;

  // Address decode: window match on addr[31:8] plus aligned word access.
  assign hit    = (bus.addr[31:8] == BASE_ADDR[31:8]) &&
                  word_access(bus.mem_type, bus.addr[1:0]);
  assign off    = bus.addr[7:0];
  assign rd_hit = bus.rd_en && hit;
  assign wr_hit = bus.wr_en && hit;

  assign wr_mtime_lo = wr_hit && (off == OFF_MTIME_LO);
  assign wr_mtime_hi = wr_hit && (off == OFF_MTIME_HI);
  assign wr_ctrl     = wr_hit && (off == OFF_CTRL);
  assign rd_mtime_lo = rd_hit && (off == OFF_MTIME_LO);

  assign cmp_ge = (mtime_reg >= mtimecmp);

  mtimer_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .cnt_en   (ctrl_reg.cnt_en),
    .prescale (ctrl_reg.prescale[PRESC_W-1:0]),
    .clr      (wr_ctrl),
    .tick     (tick)
  );

  // mtime: a software write to either half wins over a same-cycle tick, and
  // only the addressed half changes (no carry across halves).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_reg <= '0;
    end else if (wr_mtime_lo) begin
      mtime_reg[31:0] <= bus.wdata;
    end else if (wr_mtime_hi) begin
      mtime_reg[63:32] <= bus.wdata;
    end else if (tick) begin
      mtime_reg <= mtime_reg + 64'd1;
    end
  end

  // mtimecmp halves, one register per 32-bit half, each at its own offset.
  for (genvar gi = 0; gi < 2; gi++) begin : g_cmp
    localparam logic [7:0] HALF_OFF = OFF_MTIMECMP_LO + 8'(gi * 4);
    logic [31:0] half_reg;

    // Replace this half on a write hit to its offset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        half_reg <= '1;
      end else if (wr_hit && (off == HALF_OFF)) begin
        half_reg <= bus.wdata;
      end
    end
  end

  assign mtimecmp = {g_cmp[1].half_reg, g_cmp[0].half_reg};

  // High-half shadow: captured when the low half is read so a following
  // MTIME_HI read is consistent; a direct MTIME_HI write also lands here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_shadow_reg <= '0;
    end else if (wr_mtime_hi) begin
      hi_shadow_reg <= bus.wdata;
    end else if (rd_mtime_lo) begin
      hi_shadow_reg <= mtime_reg[63:32];
    end
  end

  // CTRL register; unimplemented prescale bits stay zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_reg <= '0;
    end else if (wr_ctrl) begin
      ctrl_reg                        <= '0;
      ctrl_reg.cnt_en                 <= bus.wdata[CTRL_CNT_EN_BIT];
      ctrl_reg.irq_en                 <= bus.wdata[CTRL_IRQ_EN_BIT];
      ctrl_reg.prescale[PRESC_W-1:0]  <= bus.wdata[CTRL_PRESC_LSB +: PRESC_W];
    end
  end

  // Level interrupt, registered from the pre-edge compare result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tm_interupt_reg <= 1'b0;
    end else begin
      tm_interupt_reg <= ctrl_reg.irq_en && cmp_ge;
    end
  end

  assign tm_interupt = tm_interupt_reg;

  // Zero-latency read mux; anything not a read hit returns zero.
  always_comb begin
    bus.rdata = '0;
    if (rd_hit) begin
      unique case (off)
        OFF_MTIME_LO:    bus.rdata = mtime_reg[31:0];
        OFF_MTIME_HI:    bus.rdata = hi_shadow_reg;
        OFF_MTIMECMP_LO: bus.rdata = mtimecmp[31:0];
        OFF_MTIMECMP_HI: bus.rdata = mtimecmp[63:32];
        OFF_CTRL: begin
          bus.rdata[CTRL_CNT_EN_BIT]            = ctrl_reg.cnt_en;
          bus.rdata[CTRL_IRQ_EN_BIT]            = ctrl_reg.irq_en;
          bus.rdata[CTRL_PRESC_LSB +: PRESC_W]  = ctrl_reg.prescale[PRESC_W-1:0];
        end
        OFF_STATUS: begin
          bus.rdata[0] = cmp_ge;
          bus.rdata[1] = tm_interupt_reg;
        end
        default:         bus.rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mtimer.sv
// Directed bench for mtimer: register reset values, prescaled counting,
// tear-free 64-bit read, interrupt timing, illegal accesses and async reset.
module tb_mtimer;
  import mtimer_pkg::*;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic clk;
  logic rst;
  logic tm_interupt;
  logic [31:0] rd;

  int total;
  int bad;

  mtimer_if bus_if ();

  mtimer #(
    .BASE_ADDR (BASE),
    .PRESC_W   (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if),
    .tm_interupt (tm_interupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] mt);
    @(negedge clk);
    bus_if.wr_en    = 1'b1;
    bus_if.rd_en    = 1'b0;
    bus_if.addr     = a;
    bus_if.wdata    = d;
    bus_if.mem_type = mt;
    @(negedge clk);
    bus_if.wr_en    = 1'b0;
    $display("write addr=%h data=%h type=%0d", a, d, mt);
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [2:0] mt, output logic [31:0] d);
    @(negedge clk);
    bus_if.rd_en    = 1'b1;
    bus_if.wr_en    = 1'b0;
    bus_if.addr     = a;
    bus_if.mem_type = mt;
    #1 d = bus_if.rdata;
    $display("read  addr=%h data=%h type=%0d", a, d, mt);
    @(posedge clk);
    #1 bus_if.rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus_if.rd_en    = 1'b0;
    bus_if.wr_en    = 1'b0;
    bus_if.addr     = '0;
    bus_if.wdata    = '0;
    bus_if.mem_type = MEM_WORD;
    idle(3);
    rst = 1'b0;

    // Reset values of every register.
    bus_read(BASE + 32'h00, MEM_WORD, rd); check("rst_mtime_lo", rd, 32'h0);
    bus_read(BASE + 32'h04, MEM_WORD, rd); check("rst_mtime_hi", rd, 32'h0);
    bus_read(BASE + 32'h08, MEM_WORD, rd); check("rst_cmp_lo", rd, 32'hFFFF_FFFF);
    bus_read(BASE + 32'h0C, MEM_WORD, rd); check("rst_cmp_hi", rd, 32'hFFFF_FFFF);
    bus_read(BASE + 32'h10, MEM_WORD, rd); check("rst_ctrl", rd, 32'h0);
    bus_read(BASE + 32'h14, MEM_WORD, rd); check("rst_status", rd, 32'h0);
    check("rst_irq", {31'd0, tm_interupt}, 32'h0);

    // Prescale 3: one tick every 4 cycles, 40 cycles -> 10.
    bus_write(BASE + 32'h10, 32'h0000_0301, MEM_WORD);
    idle(39);
    bus_read(BASE + 32'h00, MEM_WORD, rd); check("presc3_40cyc", rd, 32'd10);
    bus_read(BASE + 32'h10, MEM_WORD, rd); check("ctrl_readback", rd, 32'h0000_0301);

    // Prescale 0: one tick per cycle.
    bus_write(BASE + 32'h10, 32'h0000_0001, MEM_WORD);
    bus_write(BASE + 32'h00, 32'h0000_0000, MEM_WORD);
    bus_read(BASE + 32'h00, MEM_WORD, rd); check("presc0_a", rd, 32'd1);
    bus_read(BASE + 32'h00, MEM_WORD, rd); check("presc0_b", rd, 32'd2);

    // Low-to-high carry and tear-free high read.
    bus_write(BASE + 32'h10, 32'h0000_0000, MEM_WORD);
    bus_write(BASE + 32'h00, 32'hFFFF_FFFE, MEM_WORD);
    bus_write(BASE + 32'h04, 32'h0000_0000, MEM_WORD);
    bus_write(BASE + 32'h10, 32'h0000_0001, MEM_WORD);
    bus_read(BASE + 32'h00, MEM_WORD, rd); check("carry_lo_ff", rd, 32'hFFFF_FFFF);
    bus_read(BASE + 32'h04, MEM_WORD, rd); check("shadow_hi_old", rd, 32'h0);
    bus_read(BASE + 32'h00, MEM_WORD, rd); check("carry_lo_1", rd, 32'h1);
    bus_read(BASE + 32'h04, MEM_WORD, rd); check("shadow_hi_new", rd, 32'h1);

    // Interrupt timing around mtimecmp = 100.
    bus_write(BASE + 32'h10, 32'h0000_0000, MEM_WORD);
    bus_write(BASE + 32'h04, 32'h0000_0000, MEM_WORD);
    bus_write(BASE + 32'h00, 32'd90, MEM_WORD);
    bus_write(BASE + 32'h0C, 32'h0000_0000, MEM_WORD);
    bus_write(BASE + 32'h08, 32'd100, MEM_WORD);
    bus_read(BASE + 32'h14, MEM_WORD, rd); check("status_below", rd, 32'h0);
    check("irq_below", {31'd0, tm_interupt}, 32'h0);
    bus_write(BASE + 32'h10, 32'h0000_0003, MEM_WORD);
    idle(10);
    check("irq_at_match", {31'd0, tm_interupt}, 32'h0);
    @(negedge clk);
    check("irq_rise", {31'd0, tm_interupt}, 32'h1);
    bus_read(BASE + 32'h14, MEM_WORD, rd); check("status_fired", rd, 32'h3);
    bus_write(BASE + 32'h08, 32'd1000, MEM_WORD);
    check("irq_hold_edge", {31'd0, tm_interupt}, 32'h1);
    @(negedge clk);
    check("irq_fall", {31'd0, tm_interupt}, 32'h0);
    bus_read(BASE + 32'h14, MEM_WORD, rd); check("status_cleared", rd, 32'h0);

    // Illegal accesses are ignored / read zero.
    bus_write(BASE + 32'h08, 32'd5, 3'b000);
    bus_write(BASE + 32'h09, 32'd7, MEM_WORD);
    bus_write(BASE + 32'h11, 32'h0000_0000, MEM_WORD);
    bus_read(BASE + 32'h08, MEM_WORD, rd); check("cmp_unchanged", rd, 32'd1000);
    bus_read(BASE + 32'h10, MEM_WORD, rd); check("ctrl_unchanged", rd, 32'h3);
    bus_read(BASE + 32'h10, 3'b000, rd);   check("byte_read_zero", rd, 32'h0);
    bus_read(BASE + 32'h11, MEM_WORD, rd); check("misalign_read_zero", rd, 32'h0);
    bus_read(32'h8000_0108, MEM_WORD, rd); check("out_window_zero", rd, 32'h0);
    bus_read(BASE + 32'h18, MEM_WORD, rd); check("unmapped_zero", rd, 32'h0);

    // Async reset while the interrupt is asserted and counting.
    bus_write(BASE + 32'h08, 32'h0000_0000, MEM_WORD);
    idle(2);
    check("irq_before_rst", {31'd0, tm_interupt}, 32'h1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("irq_async_rst", {31'd0, tm_interupt}, 32'h0);
    bus_if.rd_en    = 1'b1;
    bus_if.mem_type = MEM_WORD;
    bus_if.addr     = BASE + 32'h00;
    #1 check("mtime_async_rst", bus_if.rdata, 32'h0);
    bus_if.addr     = BASE + 32'h0C;
    #1 check("cmp_hi_async_rst", bus_if.rdata, 32'hFFFF_FFFF);
    bus_if.rd_en    = 1'b0;
    #1 check("rdata_idle_zero", bus_if.rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus_read(BASE + 32'h00, MEM_WORD, rd); check("mtime_after_rst", rd, 32'h0);
    bus_read(BASE + 32'h10, MEM_WORD, rd); check("ctrl_after_rst", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mtimer.md
Name: mtimer

Overview:
- Memory-mapped machine timer. It is a responder on the core's data-memory bus (rd_en/wr_en/addr/wdata/mem_type/rdata) and the source of the core's timer-interrupt input.
- It holds a 64-bit free-running mtime, a 64-bit mtimecmp, a prescaler and a control register.
- It asserts a level interrupt while mtime >= mtimecmp and the interrupt is enabled.
- It is decoded alongside data_mem; the top level muxes rdata by address range.

Parameters:
- BASE_ADDR, 32'h8000_0000, base of the 256-byte register window; only addr[31:8] is compared.
- PRESC_W, 8, width of the prescale field and the prescale counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- rd_en  in  1  bus read strobe
- wr_en  in  1  bus write strobe
- mem_type  in  3  access size; only MEM_WORD (3'b010) is legal
- addr  in  32  byte address
- wdata  in  32  write data
- rdata  out  32  read data, combinational
- tm_interupt  out  1  timer interrupt to the core's CSR unit, registered

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0x00 MTIME_LO
  - 0x04 MTIME_HI
  - 0x08 MTIMECMP_LO
  - 0x0C MTIMECMP_HI
  - 0x10 CTRL: bit0 cnt_en, bit1 irq_en, bits[8+PRESC_W-1:8] prescale
  - 0x14 STATUS: read-only, bit0 = (mtime >= mtimecmp), bit1 = tm_interupt
  - All other offsets read 0; writes to them are ignored.
- Access is "hit" when addr[31:8]==BASE_ADDR[31:8], addr[1:0]==0 and mem_type==MEM_WORD.
  - Non-hit reads return 0.
  - Non-hit writes have no effect.
- Reads are combinational from current state with zero latency. Writes take effect at the next posedge clk.
- Reset values:
  - mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF
  - CTRL = 0, presc_cnt = 0, hi_shadow = 0
  - tm_interupt = 0
  - rdata = 0 when not reading
- Prescaler:
  - When cnt_en=1, presc_cnt counts 0..prescale.
  - When presc_cnt==prescale, a tick fires, presc_cnt returns to 0 and mtime increments by 1.
  - prescale=0 gives a tick every cycle.
  - When cnt_en=0, presc_cnt and mtime hold.
  - Any write to CTRL clears presc_cnt to 0.
- mtime wraps from 64'hFFFF_FFFF_FFFF_FFFF to 0 with no flag.
- Tear-free read:
  - A read hit of MTIME_LO returns mtime[31:0] and latches mtime[63:32] into hi_shadow at that edge.
  - A read of MTIME_HI returns hi_shadow, not live mtime[63:32].
- Writes to MTIME:
  - MTIME_LO replaces only [31:0] and MTIME_HI only [63:32]; there is no carry between halves.
  - A write wins over a same-cycle tick; that tick is lost, and presc_cnt still advances/resets normally.
  - A write to MTIME_HI also updates hi_shadow.
- Writes to MTIMECMP_LO or MTIMECMP_HI replace the addressed half. The compare is unsigned over the full 64 bits.
- Interrupt:
  - tm_interupt <= irq_en & (mtime >= mtimecmp), evaluated on the pre-edge state: one cycle latency from the condition becoming true.
  - It is level-sensitive and deasserts one cycle after software raises mtimecmp above mtime or clears irq_en. No write-1-to-clear.
- Simultaneous rd_en and wr_en to the same offset: rdata shows the old value; the write lands at the edge.
- Reset mid-operation: all state returns to reset values asynchronously and tm_interupt drops immediately.

Decomposition:
- Package mtimer_pkg holds:
  - Offset localparams: OFF_MTIME_LO, OFF_MTIME_HI, OFF_MTIMECMP_LO, OFF_MTIMECMP_HI, OFF_CTRL, OFF_STATUS.
  - MEM_WORD = 3'b010.
  - CTRL bit indices.
  - A packed struct ctrl_t {prescale, irq_en, cnt_en}.
- One sub-module, mtimer_prescaler (cnt_en, prescale, clr, tick), contains presc_cnt and the tick logic.
- Register file, decode, shadow and compare stay in mtimer.

Test Plan:
- Reset, then read every offset: MTIME_LO/HI = 0, MTIMECMP_LO/HI = 32'hFFFF_FFFF, CTRL = 0, STATUS = 0; tm_interupt = 0.
- Write CTRL=32'h0000_0301 (prescale 3, cnt_en), wait 40 cycles, read MTIME_LO -> 10 (±1 depending on write edge); prescale 0 -> increments every cycle.
- Write MTIME_LO=32'hFFFF_FFFE, MTIME_HI=0, prescale 0, count 3 ticks -> MTIME_LO=1; MTIME_HI read after the LO read returns 1.
- MTIMECMP = 100, irq_en+cnt_en, prescale 0, mtime = 90 -> tm_interupt rises exactly one cycle after mtime reaches 100. Then write MTIMECMP_LO=1000 -> tm_interupt falls next cycle; STATUS bit0 tracks the compare.
- Byte access (mem_type=3'b000) and misaligned addr=BASE+1 write -> registers unchanged and reads return 0. Out-of-window address -> rdata = 0.
- Assert rst while tm_interupt=1 and counting -> tm_interupt=0 and mtime=0 immediately, with no clock edge needed.
